dis_ram_tcam: RTL and testbench

DIS_RAM_TCAM -- requirements
Module: dis_ram_tcam

---
 rtl/dis_ram_tcam_pkg.sv | 24 ++
 rtl/dis_ram_tcam_chunk_ram.sv | 36 +++
 rtl/dis_ram_tcam.sv | 167 ++++++++++++++++
 tb/tb_dis_ram_tcam.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/dis_ram_tcam_pkg.sv
// Shared constants, state encoding and sizing helpers for the nibble-sliced TCAM.
// Nothing in this package depends on the DIS_RAM_TCAM_OUT_REG_EN build option.
package dis_ram_tcam_pkg;

    localparam int CHUNK_W     = 4;
    localparam int CHUNK_DEPTH = 16;

    // The table is first filled with rules, then switches to answering lookups.
    typedef enum logic {
        ST_BUILD  = 1'b0,
        ST_SEARCH = 1'b1
    } tcam_state_e;

    // Number of nibble tables needed to cover a key.
    function automatic int num_chunks(input int key_len);
        return key_len / CHUNK_W;
    endfunction

    // Width of a rule index. Kept at least 1 so a single-rule table still has a legal index.
    function automatic int idx_width(input int max_rule);
        return (max_rule > 1) ? $clog2(max_rule) : 1;
    endfunction

endpackage

// File: rtl/dis_ram_tcam_chunk_ram.sv
// One nibble table of the TCAM: 16 entries, each a MAX_RULE-bit membership vector.
// Writing rule r sets bit r in the entry named by the rule's nibble and clears it in the
// other 15, so each rule column is always one-hot. The read port is combinational.
import dis_ram_tcam_pkg::*;

module tcam_chunk_ram #(
    parameter int MAX_RULE = 64,
    parameter int IDX_W    = idx_width(MAX_RULE)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic [CHUNK_W-1:0]  wr_nibble,
    input  logic [CHUNK_W-1:0]  rd_nibble,
    output logic [MAX_RULE-1:0] rd_vec
);

    logic [MAX_RULE-1:0] bitmap_q [CHUNK_DEPTH];

    // Column write for rule wr_idx across all 16 entries; reset wipes the whole table.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int v = 0; v < CHUNK_DEPTH; v++) begin
                bitmap_q[v] <= '0;
            end
        end else if (wr_en) begin
            for (int v = 0; v < CHUNK_DEPTH; v++) begin
                bitmap_q[v][wr_idx] <= (wr_nibble == CHUNK_W'(v));
            end
        end
    end

    assign rd_vec = bitmap_q[rd_nibble];

endmodule

// File: rtl/dis_ram_tcam.sv
// Nibble-sliced exact-match TCAM: build phase fills MAX_RULE rules in order, then the
// table answers one lookup per cycle with the next hop of the lowest-index matching rule.
// Optional macro DIS_RAM_TCAM_OUT_REG_EN adds a second output register (2-cycle latency).
import dis_ram_tcam_pkg::*;

module dis_ram_tcam #(
    parameter int MAX_RULE    = 64,
    parameter int KEY_LEN     = 32,
    parameter int NEXTHOP_LEN = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   build_signal,
    input  logic [KEY_LEN-1:0]     rule_key,
    input  logic [NEXTHOP_LEN-1:0] nexthop_key,
    output logic                   build_over,
    input  logic                   search_signal,
    input  logic [KEY_LEN-1:0]     search_key,
    output logic                   match,
    output logic [NEXTHOP_LEN-1:0] nexthop
);

    localparam int NUM_CHUNKS = num_chunks(KEY_LEN);
    localparam int IDX_W      = idx_width(MAX_RULE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_RULE - 1);

    tcam_state_e            state_q;
    tcam_state_e            state_d;
    logic [IDX_W-1:0]       wr_idx;
    logic                   build_wr;
    logic                   search_en;

    logic [MAX_RULE-1:0]    chunk_vec [NUM_CHUNKS];
    logic [MAX_RULE-1:0]    hit_vec;
    logic                   hit_any;
    logic [IDX_W-1:0]       hit_sel;
    logic [NEXTHOP_LEN-1:0] lookup_nh;

    logic [NEXTHOP_LEN-1:0] nh_mem [MAX_RULE];
    logic                   match_q;
    logic [NEXTHOP_LEN-1:0] nexthop_q;

    // Phase register: reset always returns to building from entry 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_BUILD;
        end else begin
            state_q <= state_d;
        end
    end

    // Phase decode: builds are only accepted while filling, searches only once full,
    // which also gives build priority when both strobes arrive during the fill.
    always_comb begin
        state_d   = state_q;
        build_wr  = 1'b0;
        search_en = 1'b0;
        case (state_q)
            ST_BUILD: begin
                build_wr = build_signal;
                if (build_signal && (wr_idx == LAST_IDX)) begin
                    state_d = ST_SEARCH;
                end
            end
            ST_SEARCH: begin
                search_en = search_signal;
            end
            default: begin
                state_d = ST_BUILD;
            end
        endcase
    end

    assign build_over = (state_q == ST_SEARCH);

    // Write pointer advances on every accepted rule; it is parked once the table is full.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_idx <= '0;
        end else if (build_wr && (wr_idx != LAST_IDX)) begin
            wr_idx <= wr_idx + IDX_W'(1);
        end
    end

    genvar c;
    generate
        for (c = 0; c < NUM_CHUNKS; c++) begin : g_chunk
            tcam_chunk_ram #(
                .MAX_RULE (MAX_RULE),
                .IDX_W    (IDX_W)
            ) u_chunk (
                .clk       (clk),
                .rst       (rst),
                .wr_en     (build_wr),
                .wr_idx    (wr_idx),
                .wr_nibble (rule_key[c*CHUNK_W +: CHUNK_W]),
                .rd_nibble (search_key[c*CHUNK_W +: CHUNK_W]),
                .rd_vec    (chunk_vec[c])
            );
        end
    endgenerate

    // Next-hop slots written alongside the bitmaps; cleared on reset so stale data never leaks.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int r = 0; r < MAX_RULE; r++) begin
                nh_mem[r] <= '0;
            end
        end else if (build_wr) begin
            nh_mem[wr_idx] <= nexthop_key;
        end
    end

    // A rule hits only if every nibble table agrees on it.
    always_comb begin
        hit_vec = '1;
        for (int i = 0; i < NUM_CHUNKS; i++) begin
            hit_vec = hit_vec & chunk_vec[i];
        end
    end

    // Lowest-index hit wins; scanning downward lets the last assignment be the lowest one.
    always_comb begin
        hit_sel = '0;
        for (int r = MAX_RULE - 1; r >= 0; r--) begin
            if (hit_vec[r]) begin
                hit_sel = IDX_W'(r);
            end
        end
        hit_any   = |hit_vec;
        lookup_nh = hit_any ? nh_mem[hit_sel] : '0;
    end

    // Result register only updates on an accepted search, so results hold otherwise.
    always_ff @(posedge clk) begin
        if (!rst) begin
            match_q   <= 1'b0;
            nexthop_q <= '0;
        end else if (search_en) begin
            match_q   <= hit_any;
            nexthop_q <= lookup_nh;
        end
    end

`ifdef DIS_RAM_TCAM_OUT_REG_EN
    logic                   match_q2;
    logic [NEXTHOP_LEN-1:0] nexthop_q2;

    // Extra pipeline stage for timing; it follows the first stage every cycle, so holds carry through.
    always_ff @(posedge clk) begin
        if (!rst) begin
            match_q2   <= 1'b0;
            nexthop_q2 <= '0;
        end else begin
            match_q2   <= match_q;
            nexthop_q2 <= nexthop_q;
        end
    end

    assign match   = match_q2;
    assign nexthop = nexthop_q2;
`else
    assign match   = match_q;
    assign nexthop = nexthop_q;
`endif

endmodule

// File: tb/tb_dis_ram_tcam.sv
// Directed self-checking bench for dis_ram_tcam with default parameters.
// Honours DIS_RAM_TCAM_OUT_REG_EN by waiting the matching search latency.
module tb_dis_ram_tcam;

    localparam int MAX_RULE    = 64;
    localparam int KEY_LEN     = 32;
    localparam int NEXTHOP_LEN = 32;
`ifdef DIS_RAM_TCAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   build_signal;
    logic [KEY_LEN-1:0]     rule_key;
    logic [NEXTHOP_LEN-1:0] nexthop_key;
    logic                   build_over;
    logic                   search_signal;
    logic [KEY_LEN-1:0]     search_key;
    logic                   match;
    logic [NEXTHOP_LEN-1:0] nexthop;

    int check_count = 0;
    int pass_count  = 0;

    dis_ram_tcam #(
        .MAX_RULE    (MAX_RULE),
        .KEY_LEN     (KEY_LEN),
        .NEXTHOP_LEN (NEXTHOP_LEN)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .build_signal  (build_signal),
        .rule_key      (rule_key),
        .nexthop_key   (nexthop_key),
        .build_over    (build_over),
        .search_signal (search_signal),
        .search_key    (search_key),
        .match         (match),
        .nexthop       (nexthop)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        check_count++;
        if (obs !== exp) begin
            $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        end else begin
            pass_count++;
        end
    endtask

    // Inputs change on the falling edge; outputs are read on a later falling edge.
    task automatic applyReset();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic buildRule(input logic [KEY_LEN-1:0] key, input logic [NEXTHOP_LEN-1:0] nh);
        build_signal = 1'b1;
        rule_key     = key;
        nexthop_key  = nh;
        @(negedge clk);
        build_signal = 1'b0;
    endtask

    task automatic applyStimulus(input logic [KEY_LEN-1:0] key);
        search_signal = 1'b1;
        search_key    = key;
        @(negedge clk);
        search_signal = 1'b0;
        repeat (LAT - 1) @(negedge clk);
    endtask

    task automatic searchCheck(input string tag, input logic [KEY_LEN-1:0] key,
                               input logic exp_match, input logic [NEXTHOP_LEN-1:0] exp_nh);
        applyStimulus(key);
        checkOutput({tag, " match"}, 64'(match), 64'(exp_match));
        checkOutput({tag, " nexthop"}, 64'(nexthop), 64'(exp_nh));
    endtask

    initial begin
        rst           = 1'b0;
        build_signal  = 1'b0;
        rule_key      = '0;
        nexthop_key   = '0;
        search_signal = 1'b0;
        search_key    = '0;
        @(negedge clk);

        applyReset();
        checkOutput("reset match", 64'(match), 64'd0);
        checkOutput("reset nexthop", 64'(nexthop), 64'd0);
        checkOutput("reset build_over", 64'(build_over), 64'd0);

        // Full build: rule r = r*0x01010101, next hop 0xA0000000+r.
        for (int r = 0; r < MAX_RULE; r++) begin
            buildRule(32'(r) * 32'h0101_0101, 32'hA000_0000 + 32'(r));
            checkOutput($sformatf("build_over after write %0d", r), 64'(build_over),
                        64'(r == MAX_RULE - 1));
        end

        searchCheck("hit 05050505", 32'h0505_0505, 1'b1, 32'hA000_0005);

        // Results must hold while search_signal is low, even with a different key present.
        search_key = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("hold hit match %0d", i), 64'(match), 64'd1);
            checkOutput($sformatf("hold hit nexthop %0d", i), 64'(nexthop), 64'hA000_0005);
        end

        searchCheck("miss DEADBEEF", 32'hDEAD_BEEF, 1'b0, 32'h0);
        search_key = 32'h0505_0505;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("hold miss match %0d", i), 64'(match), 64'd0);
        end

        searchCheck("hit 00000000", 32'h0000_0000, 1'b1, 32'hA000_0000);
        searchCheck("hit 3F3F3F3F", 32'h3F3F_3F3F, 1'b1, 32'hA000_003F);
        searchCheck("near miss 05050504", 32'h0505_0504, 1'b0, 32'h0);

        // Writes after the table is full are dropped.
        buildRule(32'hCAFE_BABE, 32'h0000_0011);
        searchCheck("post-full write ignored", 32'hCAFE_BABE, 1'b0, 32'h0);
        searchCheck("entry 0 untouched", 32'h0000_0000, 1'b1, 32'hA000_0000);

        // Leave a hit showing, then reset and confirm it is cleared.
        searchCheck("pre-reset hit", 32'h0A0A_0A0A, 1'b1, 32'hA000_000A);
        applyReset();
        checkOutput("reset2 match", 64'(match), 64'd0);
        checkOutput("reset2 nexthop", 64'(nexthop), 64'd0);
        checkOutput("reset2 build_over", 64'(build_over), 64'd0);

        // Partial build with throwaway keys; searches during the fill must be ignored.
        for (int r = 0; r < 9; r++) begin
            buildRule(32'hF000_0000 + 32'(r), 32'hC000_0000 + 32'(r));
        end
        search_signal = 1'b1;
        search_key    = 32'hF000_0000;
        @(negedge clk);
        search_signal = 1'b0;
        repeat (LAT) @(negedge clk);
        checkOutput("search during build match", 64'(match), 64'd0);
        search_signal = 1'b1;
        buildRule(32'hF000_0009, 32'hC000_0009);
        search_signal = 1'b0;
        repeat (LAT) @(negedge clk);
        checkOutput("build priority match", 64'(match), 64'd0);
        checkOutput("partial build_over", 64'(build_over), 64'd0);

        applyReset();

        // Rebuild: same pattern but rules 3 and 9 share 0x12345678, next hop 0xB0000000+r.
        for (int r = 0; r < MAX_RULE; r++) begin
            if (r == 3 || r == 9) begin
                buildRule(32'h1234_5678, 32'hB000_0000 + 32'(r));
            end else begin
                buildRule(32'(r) * 32'h0101_0101, 32'hB000_0000 + 32'(r));
            end
        end
        checkOutput("rebuild build_over", 64'(build_over), 64'd1);

        searchCheck("duplicate lowest wins", 32'h1234_5678, 1'b1, 32'hB000_0003);
        searchCheck("old key 0 misses", 32'hF000_0000, 1'b0, 32'h0);
        searchCheck("old key 9 misses", 32'hF000_0009, 1'b0, 32'h0);
        searchCheck("new entry 0", 32'h0000_0000, 1'b1, 32'hB000_0000);
        searchCheck("new entry 5", 32'h0505_0505, 1'b1, 32'hB000_0005);
        searchCheck("replaced 03030303 misses", 32'h0303_0303, 1'b0, 32'h0);
        searchCheck("replaced 09090909 misses", 32'h0909_0909, 1'b0, 32'h0);
        searchCheck("new entry 63", 32'h3F3F_3F3F, 1'b1, 32'hB000_003F);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
